// File: rtl/csr_stream_encoder.sv
// Dense-to-CSR encoder: turns a row-major stream of dense elements into value,
// column-index and row-pointer RAM writes in the layout the CSR multiplier reads.
module csr_stream_encoder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter int N_ROWS = 1120,
    parameter int N_COLS = 1120,   // must be >= 2 so the flush write never meets a row-start write
    parameter int IDX_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              val_we,
    output logic [ADDR_W-1:0] val_addr,
    output logic [DATA_W-1:0] val_din,
    output logic              col_we,
    output logic [ADDR_W-1:0] col_addr,
    output logic [DATA_W-1:0] col_din,
    output logic              row_we,
    output logic [ADDR_W-1:0] row_addr,
    output logic [DATA_W-1:0] row_din,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   nnz,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t           state;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;

    logic           accept;
    logic           nonzero;
    logic           store;
    logic           drop;
    logic           last_col;
    logic           last_beat;
    logic [ADDR_W:0] nnz_next;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        accept    = 1'b0;
        nonzero   = 1'b0;
        store     = 1'b0;
        drop      = 1'b0;
        last_col  = 1'b0;
        last_beat = 1'b0;
        nnz_next  = nnz;

        accept    = in_valid && in_ready;
        nonzero   = (in_data != '0);
        store     = accept && nonzero && (nnz != CAPACITY);
        drop      = accept && nonzero && (nnz == CAPACITY);
        last_col  = (col == IDX_W'(N_COLS - 1));
        last_beat = accept && last_col && (row == IDX_W'(N_ROWS - 1));
        nnz_next  = nnz + {{ADDR_W{1'b0}}, store};
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            in_ready <= 1'b0;
            val_we   <= 1'b0;
            val_addr <= '0;
            val_din  <= '0;
            col_we   <= 1'b0;
            col_addr <= '0;
            col_din  <= '0;
            row_we   <= 1'b0;
            row_addr <= '0;
            row_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nnz      <= '0;
            overflow <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            val_we <= 1'b0;
            col_we <= 1'b0;
            row_we <= 1'b0;
            done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        nnz      <= '0;
                        overflow <= 1'b0;
                        row      <= '0;
                        col      <= '0;
                    end
                end

                RUN: begin
                    if (accept) begin
                        if (col == '0) begin
                            row_we   <= 1'b1;
                            row_addr <= ADDR_W'(row);
                            row_din  <= DATA_W'(nnz);
                        end
                        if (store) begin
                            val_we   <= 1'b1;
                            val_addr <= nnz[ADDR_W-1:0];
                            val_din  <= in_data;
                            col_we   <= 1'b1;
                            col_addr <= nnz[ADDR_W-1:0];
                            col_din  <= DATA_W'(col);
                        end
                        if (drop) begin
                            overflow <= 1'b1;
                        end
                        nnz <= nnz_next;

                        // The terminating row pointer is issued alongside the last
                        // beat's writes so it is visible during FLUSH.
                        if (last_beat) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            row_we   <= 1'b1;
                            row_addr <= ADDR_W'(N_ROWS);
                            row_din  <= DATA_W'(nnz_next);
                        end else if (last_col) begin
                            col <= '0;
                            row <= row + IDX_W'(1);
                        end else begin
                            col <= col + IDX_W'(1);
                        end
                    end
                end

                FLUSH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
